// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: bit-serial framed bitstream to addressed LUT config writes.
// Define CFG_CRC_EN to require and check a trailing XOR checksum byte per frame.
module clb_cfg_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_din,
  input  logic              cfg_dvalid,
  output logic              cfg_ready,
  input  logic              cfg_abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {HUNT, ADDR, COUNT, DATA, CHECK} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, sh_n, wr_data_q, wr_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic wr_valid_q, wr_valid_d, done_q, done_d, take, byte_done;
`ifdef CFG_CRC_EN
  logic [7:0] csum_q, csum_d;
  logic err_q, err_d;
  localparam state_t AFTER_DATA = CHECK;
  localparam logic CRC = 1'b1;
`else
  localparam state_t AFTER_DATA = HUNT;
  localparam logic CRC = 1'b0;
`endif
  assign cfg_ready = !wr_valid_q;
  assign take = cfg_dvalid && cfg_ready;
  assign sh_n = {shift_q[DATA_W-2:0], cfg_din};
  assign byte_done = take && cnt_q == 3'd7;
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done = done_q;
  assign busy = state_q != HUNT || wr_valid_q;
`ifdef CFG_CRC_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    shift_d = take ? sh_n : shift_q;
    cnt_d = take && state_q != HUNT ? cnt_q + 3'd1 : cnt_q;
    rem_d = rem_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d = 1'b0;
`ifdef CFG_CRC_EN
    err_d = 1'b0;
    csum_d = byte_done && state_q inside {ADDR, COUNT, DATA} ? csum_q ^ sh_n : csum_q;
`endif
    case (state_q)
      HUNT: if (take && sh_n == SYNC_WORD) begin
        state_d = ADDR;
        cnt_d = 3'd0;
`ifdef CFG_CRC_EN
        csum_d = 8'd0;
`endif
      end
      ADDR: if (byte_done) begin
        wr_addr_d = sh_n[ADDR_W-1:0];
        state_d = COUNT;
      end
      COUNT: if (byte_done) begin
        rem_d = sh_n;
        state_d = sh_n == 8'd0 ? AFTER_DATA : DATA;
        done_d = !CRC && sh_n == 8'd0;
      end
      DATA: if (byte_done) begin
        wr_valid_d = 1'b1;
        wr_data_d = sh_n;
      end else if (wr_valid_q && wr_ready) begin
        wr_valid_d = 1'b0;
        wr_addr_d = wr_addr_q + 1'b1;
        rem_d = rem_q - 8'd1;
        state_d = rem_q == 8'd1 ? AFTER_DATA : DATA;
        done_d = !CRC && rem_q == 8'd1;
      end
`ifdef CFG_CRC_EN
      CHECK: if (byte_done) begin
        done_d = sh_n == csum_q;
        err_d = sh_n != csum_q;
        state_d = HUNT;
      end
`endif
      default: ;
    endcase
    // abort beats a byte completing in the same cycle and drops any pending write
    if (cfg_abort) begin
      state_d = HUNT;
      wr_valid_d = 1'b0;
      cnt_d = 3'd0;
      shift_d = '0;
      done_d = 1'b0;
`ifdef CFG_CRC_EN
      err_d = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      shift_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q <= 1'b0;
`ifdef CFG_CRC_EN
      csum_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q <= done_d;
`ifdef CFG_CRC_EN
      csum_q <= csum_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: directed-vector bench for clb_cfg_loader (CRC on or off via CFG_CRC_EN).
module tb_clb_cfg_loader;
  logic clk, rst, cfg_din, cfg_dvalid, cfg_ready, cfg_abort;
  logic wr_valid, wr_ready, busy, done, err;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0, n_done = 0, n_err = 0, n_both = 0;
  logic [13:0] wq[$];
  logic [7:0] frm[$];
  clb_cfg_loader dut (
    .clk(clk), .rst(rst), .cfg_din(cfg_din), .cfg_dvalid(cfg_dvalid), .cfg_ready(cfg_ready),
    .cfg_abort(cfg_abort), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst) begin
    if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
    if (done) n_done++;
    if (err) n_err++;
    if (done && err) n_both++;
  end
  task automatic send_bit(input logic b);
    int w = 0;
    cfg_din = b;
    cfg_dvalid = 1;
    while (!cfg_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (w == 50) begin total++; bad++; $display("FAIL send_bit: cfg_ready stuck at %b, want 1", cfg_ready); end
    @(posedge clk); #1;
    cfg_dvalid = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask
  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear();
    cfg_abort = 1;
    idle(1);
    cfg_abort = 0;
    wq.delete();
    n_done = 0;
    n_err = 0;
  endtask
  task automatic test_reset();
    total++;
    if ({wr_valid, wr_addr, wr_data, busy, done, err, cfg_ready} !== {1'b0, 6'd0, 8'd0, 3'b000, 1'b1}) begin
      bad++; $display("FAIL reset: outputs=%h want %h", {wr_valid, wr_addr, wr_data, busy, done, err, cfg_ready}, {1'b0, 6'd0, 8'd0, 3'b000, 1'b1});
    end
  endtask
  task automatic test_basic();
    clear();
    wr_ready = 1;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h02); send_byte(8'h3C);
    total++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 6'd5, 8'h3C}) begin
      bad++; $display("FAIL basic_latency: v/a/d=%b/%h/%h want 1/05/3c", wr_valid, wr_addr, wr_data);
    end
    send_byte(8'hC3);
`ifdef CFG_CRC_EN
    send_byte(8'hF8);
`endif
    idle(5);
    total++;
    if (wq.size() !== 2) begin bad++; $display("FAIL basic_nwr: got %0d want 2", wq.size()); end
    else begin
      total++;
      if (wq[0] !== {6'd5, 8'h3C} || wq[1] !== {6'd6, 8'hC3}) begin
        bad++; $display("FAIL basic_wr: got %h %h want 053c 06c3", wq[0], wq[1]);
      end
    end
    total++;
    if (n_done !== 1 || n_err !== 0 || busy !== 0) begin
      bad++; $display("FAIL basic_status: done=%0d err=%0d busy=%b want 1 0 0", n_done, n_err, busy);
    end
  endtask
  task automatic test_zero_count();
    clear();
    frm = '{8'hA5, 8'h05, 8'h00};
`ifdef CFG_CRC_EN
    frm.push_back(8'h05);
`endif
    send_frame();
    idle(3);
    total++;
    if (wq.size() !== 0 || n_done !== 1 || n_err !== 0) begin
      bad++; $display("FAIL zero_count: wr=%0d done=%0d err=%0d want 0 1 0", wq.size(), n_done, n_err);
    end
  endtask
`ifdef CFG_CRC_EN
  task automatic test_checksum_err();
    clear();
    frm = '{8'hA5, 8'h05, 8'h02, 8'h3C, 8'hC3, 8'h00};
    send_frame();
    idle(4);
    total++;
    if (wq.size() !== 2 || n_err !== 1 || n_done !== 0 || busy !== 0) begin
      bad++; $display("FAIL csum_err: wr=%0d err=%0d done=%0d busy=%b want 2 1 0 0", wq.size(), n_err, n_done, busy);
    end
  endtask
`endif
  task automatic test_backpressure();
    clear();
    wr_ready = 0;
    frm = '{8'hA5, 8'h10, 8'h02, 8'h5A, 8'h96};
`ifdef CFG_CRC_EN
    frm.push_back(8'hDE);
`endif
    fork
      send_frame();
      begin
        int w = 0;
        while (!wr_valid && w < 200) begin @(negedge clk); w++; end
        repeat (10) begin
          @(negedge clk);
          total++;
          if ({wr_valid, cfg_ready, wr_addr, wr_data} !== {2'b10, 6'h10, 8'h5A}) begin
            bad++; $display("FAIL bp_hold: v/rdy/a/d=%b/%b/%h/%h want 1/0/10/5a", wr_valid, cfg_ready, wr_addr, wr_data);
          end
        end
        @(posedge clk); #1;
        wr_ready = 1;
      end
    join
    idle(5);
    total++;
    if (wq.size() !== 2) begin bad++; $display("FAIL bp_nwr: got %0d want 2", wq.size()); end
    else begin
      total++;
      if (wq[0] !== {6'h10, 8'h5A} || wq[1] !== {6'h11, 8'h96}) begin
        bad++; $display("FAIL bp_wr: got %h %h want 105a 1196", wq[0], wq[1]);
      end
    end
    total++;
    if (n_done !== 1) begin bad++; $display("FAIL bp_done: got %0d want 1", n_done); end
  endtask
  task automatic test_wrap();
    clear();
    frm = '{8'hA5, 8'h3F, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef CFG_CRC_EN
    frm.push_back(8'h3C);
`endif
    send_frame();
    idle(4);
    total++;
    if (wq.size() !== 3) begin bad++; $display("FAIL wrap_nwr: got %0d want 3", wq.size()); end
    else begin
      total++;
      if (wq[0] !== {6'h3F, 8'h11} || wq[1] !== {6'h00, 8'h22} || wq[2] !== {6'h01, 8'h33}) begin
        bad++; $display("FAIL wrap_wr: got %h %h %h want 3f11 0022 0133", wq[0], wq[1], wq[2]);
      end
    end
    total++;
    if (n_done !== 1 || n_err !== 0) begin bad++; $display("FAIL wrap_done: done=%0d err=%0d want 1 0", n_done, n_err); end
  endtask
  task automatic test_hunt_abort();
    clear();
    wr_ready = 0;
    send_bit(1); send_bit(0); send_bit(1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h77);
    total++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 6'd2, 8'h77}) begin
      bad++; $display("FAIL hunt_align: v/a/d=%b/%h/%h want 1/02/77", wr_valid, wr_addr, wr_data);
    end
    cfg_abort = 1;
    idle(1);
    cfg_abort = 0;
    total++;
    if (wr_valid !== 0 || busy !== 0) begin bad++; $display("FAIL abort_drop: wr_valid=%b busy=%b want 0 0", wr_valid, busy); end
    wr_ready = 1;
    idle(5);
    total++;
    if (wq.size() !== 0 || n_done !== 0 || n_err !== 0) begin
      bad++; $display("FAIL abort_quiet: wr=%0d done=%0d err=%0d want 0 0 0", wq.size(), n_done, n_err);
    end
  endtask
  task automatic test_async_rst();
    clear();
    wr_ready = 0;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h02); send_byte(8'h3C);
    #2 rst = 1;
    #1;
    total++;
    if ({wr_valid, wr_addr, wr_data, busy, done, err, cfg_ready} !== {1'b0, 6'd0, 8'd0, 3'b000, 1'b1}) begin
      bad++; $display("FAIL async_rst: outputs=%h want %h", {wr_valid, wr_addr, wr_data, busy, done, err, cfg_ready}, {1'b0, 6'd0, 8'd0, 3'b000, 1'b1});
    end
    @(negedge clk);
    rst = 0;
    wr_ready = 1;
    idle(1);
    wq.delete();
    n_done = 0;
    frm = '{8'hA5, 8'h05, 8'h02, 8'h3C, 8'hC3};
`ifdef CFG_CRC_EN
    frm.push_back(8'hF8);
`endif
    send_frame();
    idle(4);
    total++;
    if (wq.size() !== 2 || n_done !== 1) begin bad++; $display("FAIL rst_reload: wr=%0d done=%0d want 2 1", wq.size(), n_done); end
    else begin
      total++;
      if (wq[0] !== {6'd5, 8'h3C} || wq[1] !== {6'd6, 8'hC3}) begin
        bad++; $display("FAIL rst_reload_wr: got %h %h want 053c 06c3", wq[0], wq[1]);
      end
    end
  endtask
  initial begin
    rst = 1; cfg_din = 0; cfg_dvalid = 0; cfg_abort = 0; wr_ready = 1;
    idle(2);
    test_reset();
    @(negedge clk);
    rst = 0;
    idle(1);
    test_basic();
    test_zero_count();
`ifdef CFG_CRC_EN
    test_checksum_err();
`endif
    test_backpressure();
    test_wrap();
    test_hunt_abort();
    test_async_rst();
    total++;
    if (n_both !== 0) begin bad++; $display("FAIL done_err_overlap: got %0d want 0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
